// File: rtl/wb_regfile_pkg.sv
// Shared write-back / register-file constants and helpers.
// The ID/EX and forwarding logic import the same definitions.
package wb_regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned CNT_W_DEF  = 32;

    // Architectural zero register index.
    localparam int unsigned REG_ZERO = 0;

    // Source selected for one operand read port.
    typedef enum logic [1:0] {
        RD_STORED = 2'd0,
        RD_BYPASS = 2'd1,
        RD_ZERO   = 2'd2
    } rd_src_e;

    // A write-back commits only when it is enabled and targets a real register.
    function automatic logic is_commit(input logic en, input logic addr_nonzero);
        return en & addr_nonzero;
    endfunction

endpackage

// File: rtl/wb_regfile_bypass_mux.sv
// Per-read-port operand select: zero register, same-cycle write-back
// forwarding, or the stored register-file entry.
module wb_bypass_mux
    import wb_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned BYPASS = 1
) (
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] stored_i,
    input  logic              wb_en_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] rd_data_o
);

    rd_src_e src;

    // Pick the operand source; register 0 wins over any forwarding.
    always_comb begin
        src = RD_STORED;
        if (rd_addr_i == ADDR_W'(REG_ZERO)) begin
            src = RD_ZERO;
        end else if ((BYPASS != 0) && wb_en_i && (wb_addr_i == rd_addr_i)) begin
            src = RD_BYPASS;
        end
    end

    // Drive the operand from the selected source.
    always_comb begin
        rd_data_o = stored_i;
        case (src)
            RD_ZERO:   rd_data_o = '0;
            RD_BYPASS: rd_data_o = wb_data_i;
            default:   rd_data_o = stored_i;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back register file: commits the MEM/WB write-back triple into a
// 2**ADDR_W entry array, serves two bypassed ID operand reads, a registered
// debug read port and a committed-write counter.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned BYPASS = 1,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MW_RegWrite,
    input  logic [ADDR_W-1:0] MW_WBAddr,
    input  logic [DATA_W-1:0] MW_WBData,
    input  logic [ADDR_W-1:0] ID_Rs,
    input  logic [ADDR_W-1:0] ID_Rt,
    output logic [DATA_W-1:0] ID_RsData,
    output logic [DATA_W-1:0] ID_RtData,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [CNT_W-1:0]  wb_count,
    output logic [ADDR_W-1:0] wb_last_addr
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DATA_W-1:0] dbg_q, dbg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic              commit;

    // Qualify the incoming write-back; writes to register 0 are discarded.
    always_comb begin
        commit = is_commit(MW_RegWrite, MW_WBAddr != ADDR_W'(REG_ZERO));
    end

    // Next-state for the array, counter and last-address tracker.
    always_comb begin
        regs_d = regs_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        if (commit) begin
            regs_d[MW_WBAddr] = MW_WBData;
            cnt_d             = cnt_q + CNT_W'(1);
            last_d            = MW_WBAddr;
        end
    end

    // Debug read samples the post-write array so a same-edge write is seen.
    always_comb begin
        dbg_d = regs_d[dbg_addr];
        if (dbg_addr == ADDR_W'(REG_ZERO)) begin
            dbg_d = '0;
        end
    end

    // State update with synchronous active-low reset dropping any write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            dbg_q  <= '0;
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            regs_q <= regs_d;
            dbg_q  <= dbg_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    wb_bypass_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rs_mux (
        .rd_addr_i (ID_Rs),
        .stored_i  (regs_q[ID_Rs]),
        .wb_en_i   (MW_RegWrite),
        .wb_addr_i (MW_WBAddr),
        .wb_data_i (MW_WBData),
        .rd_data_o (ID_RsData)
    );

    wb_bypass_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rt_mux (
        .rd_addr_i (ID_Rt),
        .stored_i  (regs_q[ID_Rt]),
        .wb_en_i   (MW_RegWrite),
        .wb_addr_i (MW_WBAddr),
        .wb_data_i (MW_WBData),
        .rd_data_o (ID_RtData)
    );

    assign dbg_data     = dbg_q;
    assign wb_count     = cnt_q;
    assign wb_last_addr = last_q;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back consumer of the MEM/WB pipeline register: receives the registered write-back triple (enable, address, data) and commits it into the 32-entry general-purpose register file.
- Serves the two ID-stage operand reads with write-through bypass, so a value written back this cycle is visible to the instruction being decoded in the same cycle.
- Provides a debug read port and a committed-write counter for bench and board inspection.

Parameters:
- DATA_W, 32, register and data width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = read returns the stored value only.
- CNT_W, 32, width of the committed-write counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- MW_RegWrite  in  1  write-back enable from MEM/WB.
- MW_WBAddr  in  ADDR_W  destination register.
- MW_WBData  in  DATA_W  write-back data.
- ID_Rs  in  ADDR_W  read address A.
- ID_Rt  in  ADDR_W  read address B.
- ID_RsData  out  DATA_W  read data A (combinational).
- ID_RtData  out  DATA_W  read data B (combinational).
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  debug read data (registered, 1-cycle latency).
- wb_count  out  CNT_W  number of committed writes since reset.
- wb_last_addr  out  ADDR_W  address of the most recent committed write.

Behaviour:
- Reset: reset is synchronous and active-low; on a clk rising edge with rst_n=0, all entries, dbg_data, wb_count and wb_last_addr are cleared to 0. A write presented in the same cycle as reset is dropped.
- Commit:
  - A write commits at the rising edge when MW_RegWrite=1, MW_WBAddr!=0 and rst_n=1.
  - A commit writes MW_WBData into the entry, increments wb_count and updates wb_last_addr.
  - MW_RegWrite=1 with MW_WBAddr=0 is not a commit: register 0 is unchanged, the counter is unchanged and wb_last_addr is unchanged.
- Register 0: always reads 0 on all read ports, including the debug port, regardless of bypass.
- Operand reads: purely combinational, with zero latency from ID_Rs/ID_Rt to the data outputs.
  - BYPASS=1: if MW_RegWrite=1, MW_WBAddr!=0 and MW_WBAddr equals the read address, the output is MW_WBData; otherwise it is the stored entry.
  - Both ports bypass independently; Rs==Rt==WBAddr returns MW_WBData on both.
  - BYPASS=0: the output is the stored entry; the new value is visible from the cycle after the commit edge.
- Debug read: dbg_data is registered from the stored array, sampled after the same edge's write, i.e. write-first. Same-edge write to dbg_addr makes dbg_data show the new value one cycle after the edge.
- Counter: wb_count wraps modulo 2**CNT_W without saturation or flag.
- Mid-operation reset: deasserting rst_n for one edge clears the state fully; the next edge with rst_n=1 resumes normal commits.
- No X propagation: all outputs are defined from the first edge after reset.

Decomposition:
- Shared package constants: REG_ZERO=0, default DATA_W/ADDR_W. These are shared with the ID/EX and forwarding logic.
- One sub-module is natural: wb_bypass_mux (address compare plus select, instantiated per read port).
- The storage array and counter live in the top module.

Test Plan:
- Reset then read: hold rst_n=0 for 2 edges, release, ID_Rs=5, ID_Rt=31 -> both read 0; wb_count=0.
- Basic commit: write r7=0xDEADBEEF, next cycle ID_Rs=7 -> 0xDEADBEEF; wb_count=1, wb_last_addr=7.
- Same-cycle bypass: MW_RegWrite=1, addr 3, data 0x12345678, ID_Rs=ID_Rt=3 in the same cycle -> both outputs 0x12345678 before the edge (BYPASS=1); stored value unchanged until the edge. With BYPASS=0 -> old value (0) that cycle, 0x12345678 the next cycle.
- Zero register: MW_RegWrite=1, addr 0, data 0xFFFFFFFF -> ID_Rs=0 reads 0 same cycle and after; wb_count unchanged; dbg_addr=0 -> dbg_data=0.
- Reset collision and mid-run reset: write r9=0xA5A5A5A5 with rst_n=0 on that edge -> r9 reads 0. Then commit 4 writes, pulse rst_n low for one edge -> all registers 0, wb_count=0, wb_last_addr=0; the next write r2=1 -> wb_count=1.
- Counter wrap (CNT_W=4): 17 commits -> wb_count=1; debug port dbg_addr=2 after a write to r2=0x55 -> dbg_data=0x55 one cycle later.
